alu32_seq: RTL and testbench
============================

# alu32_seq

Sequential 32-bit ALU stage that consumes operand pairs from the register-read stage and delivers a registered result with status flags to writeback. It evaluates bitwise NOT/AND/OR/XOR and ADD/SUB in one cycle, and evaluates shifts iteratively at one bit per cycle. Valid/ready handshakes on both sides decouple it from its neighbours. It accepts one operation at a time.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Only 32 is supported; the shift count is 5 bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: the operation on `op`/`a`/`b` is valid.
- `in_ready`  out  1: the stage can accept an operation.
- `op`  in  4: opcode.
- `a`  in  32: operand A.
- `b`  in  32: operand B. For shifts, the shift amount is `b[4:0]`.
- `out_valid`  out  1: `result` and the flags are valid.
- `out_ready`  in  1: the consumer accepts the result.
- `result`  out  32: ALU result.
- `zero`  out  1: high when `result` == 0.
- `carry`  out  1: carry/no-borrow flag.
- `overflow`  out  1: signed-overflow flag.
- `illegal`  out  1: the opcode was unsupported.

## Operation
- Opcodes:
  - 0 NOT (~a)
  - 1 AND
  - 2 OR
  - 3 XOR
  - 4 ADD
  - 5 SUB (a-b)
  - 6 SLL
  - 7 SRL
  - 8 SRA
  - 9–15 illegal
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `op`/`a`/`b`.
    - Non-shift op, or shift with amount 0: compute, go to DONE.
    - Shift with amount > 0: load the shift register with `a`, load the counter with the amount, go to SHIFT.
  - SHIFT: each cycle, shift the register by 1 and decrement the counter. When the counter reaches 1 (the last shift is applied that cycle), go to DONE. SRA replicates bit 31.
  - DONE: `out_valid`=1. All outputs are held stable until `out_ready`; on handshake, return to IDLE.
- `in_ready` is high only in IDLE. No new operation is accepted while SHIFT or DONE is pending.
- Flags:
  - ADD: carry = bit 32 of the 33-bit sum. Overflow = operands share a sign and the result sign differs.
  - SUB: carry = 1 when a >= b unsigned (no borrow). Overflow = operand signs differ and the result sign differs from a.
  - Logic ops and shifts: carry=0, overflow=0.
  - Illegal opcode: result=0, zero=1, carry=0, overflow=0, illegal=1. Latency is the same as a single-cycle op.
- Arithmetic wraps modulo 2^32.

## Timing
- Reset (async, at any time, including mid-shift):
  - state=IDLE.
  - `out_valid`=0, `result`=0, `zero`=0, `carry`=0, `overflow`=0, `illegal`=0.
  - Internal counter and shift register are cleared.
  - `in_ready`=1 once reset is released.
- Single-cycle op accepted at edge N: `out_valid` is high after edge N+1... more precisely, `out_valid` rises after edge N and is visible during cycle N+1.
- Shift with amount k ≥ 1 accepted at edge N: `out_valid` is visible after edge N+k.
- Back-to-back throughput for single-cycle ops, with `out_ready` tied high: one operation every 2 cycles (accept, then DONE).
- `out_ready` held low: the result, flags, and `out_valid` are held indefinitely, and `in_ready` stays 0.
- `out_valid` never depends combinationally on `out_ready`.
- `in_ready` depends only on state, never combinationally on inputs.

## Configuration
- `ALU32_SHIFT_EN` defined:
  - Opcodes 6–8 are implemented as described, including the SHIFT state and the 5-bit counter.
- `ALU32_SHIFT_EN` undefined:
  - Opcodes 6–8 are treated as illegal (result=0, illegal=1, single-cycle latency).
  - The SHIFT state, counter, and shift register are not compiled.

## Structure
- Shared package `alu32_pkg`:
  - `alu_op_e`, a 4-bit opcode enum.
  - `alu_state_e` (IDLE/SHIFT/DONE).
  - `ALU_W`=32 and `SHAMT_W`=5.
- One sub-module, `alu32_comb`: purely combinational evaluation of the single-cycle ops and their flags. The top level holds the FSM, the operand and result registers, and the shift datapath.

## Test plan
- Reset asserted mid-SHIFT (SLL, a=1, b=20, reset after 5 cycles) -> all outputs 0 at once, `in_ready`=1 after release, no stale `out_valid`.
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, carry=0, zero=0, `out_valid` visible one cycle after accept.
- SUB a=5, b=5 -> result=0, zero=1, carry=1. SUB a=0, b=1 -> result=0xFFFFFFFF, carry=0.
- SRA a=0x80000000, b=31 -> result=0xFFFFFFFF after 31 cycles. SLL with b=0 -> result=a after 1 cycle. With `ALU32_SHIFT_EN` undefined, the same SRA -> illegal=1, result=0.
- NOT a=0x0F0F0F0F with `out_ready` held low for 10 cycles -> result=0xF0F0F0F0 stable throughout, `in_ready`=0. Released -> `in_ready`=1 on the next cycle.
- op=12 -> illegal=1, result=0, zero=1. A following AND a=0xFF, b=0x0F -> result=0x0F, illegal=0.

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared types and constants for the alu32_seq ALU stage.
// The optional shift datapath is controlled by the ALU32_SHIFT_EN macro.
package alu32_pkg;

    localparam int ALU_W   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_NOT = 4'd0,
        OP_AND = 4'd1,
        OP_OR  = 4'd2,
        OP_XOR = 4'd3,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // True for the three opcodes that use the iterative shifter.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu32_comb.sv
// Single-cycle evaluation of logic and add/sub ops with their status flags.
// With ALU32_SHIFT_EN defined, shift opcodes pass operand A through (the
// shift-by-zero result); nonzero amounts are handled by the top level.
// Without it, shift opcodes report illegal like any unsupported opcode.
module alu32_comb
    import alu32_pkg::*;
(
    input  logic [3:0]       i_op,
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    output logic [ALU_W-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_illegal
);

    logic [ALU_W:0] w_sum;
    logic [ALU_W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Opcode decode; illegal opcodes yield zero result and clear flags.
    always_comb begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        o_illegal  = 1'b0;
        case (i_op)
            OP_NOT: o_result = ~i_a;
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_ADD: begin
                o_result   = w_sum[ALU_W-1:0];
                o_carry    = w_sum[ALU_W];
                o_overflow = (i_a[ALU_W-1] == i_b[ALU_W-1]) &&
                             (w_sum[ALU_W-1] != i_a[ALU_W-1]);
            end
            OP_SUB: begin
                o_result   = w_diff[ALU_W-1:0];
                // Bit 32 of the wide difference is the borrow.
                o_carry    = ~w_diff[ALU_W];
                o_overflow = (i_a[ALU_W-1] != i_b[ALU_W-1]) &&
                             (w_diff[ALU_W-1] != i_a[ALU_W-1]);
            end
`ifdef ALU32_SHIFT_EN
            OP_SLL, OP_SRL, OP_SRA: o_result = i_a;
`endif
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu32_seq.sv
// Sequential 32-bit ALU stage with valid/ready handshakes on both sides.
// Single-cycle ops complete in one state transition; shifts (when the
// ALU32_SHIFT_EN macro is defined) iterate one bit per cycle.
module alu32_seq
    import alu32_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    alu_state_e       r_state;
    alu_state_e       w_state_nxt;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_illegal;

    logic [ALU_W-1:0] w_c_result;
    logic             w_c_carry;
    logic             w_c_overflow;
    logic             w_c_illegal;
    logic             w_accept;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;

    assign result   = r_result;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign illegal  = r_illegal;

    alu32_comb u_comb (
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .o_result   (w_c_result),
        .o_carry    (w_c_carry),
        .o_overflow (w_c_overflow),
        .o_illegal  (w_c_illegal)
    );

`ifdef ALU32_SHIFT_EN
    logic [3:0]         r_op;
    logic [ALU_W-1:0]   r_shreg;
    logic [SHAMT_W-1:0] r_cnt;
    logic [ALU_W-1:0]   w_sh_next;
    logic               w_start_shift;
    logic               w_last_shift;

    assign w_start_shift = w_accept && is_shift_op(op) &&
                           (b[SHAMT_W-1:0] != '0);
    assign w_last_shift  = (r_state == ST_SHIFT) && (r_cnt == SHAMT_W'(1));

    // One-bit shift of the working register in the latched direction.
    always_comb begin
        w_sh_next = r_shreg;
        case (r_op)
            OP_SLL:  w_sh_next = {r_shreg[ALU_W-2:0], 1'b0};
            OP_SRL:  w_sh_next = {1'b0, r_shreg[ALU_W-1:1]};
            OP_SRA:  w_sh_next = {r_shreg[ALU_W-1], r_shreg[ALU_W-1:1]};
            default: w_sh_next = r_shreg;
        endcase
    end

    // Shift register and remaining-count down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_start_shift) begin
            r_op    <= op;
            r_shreg <= a;
            r_cnt   <= b[SHAMT_W-1:0];
        end else if (r_state == ST_SHIFT) begin
            r_shreg <= w_sh_next;
            r_cnt   <= r_cnt - SHAMT_W'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; counter value 1 marks the final shift cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_DONE;
                end
`ifdef ALU32_SHIFT_EN
                if (w_start_shift) begin
                    w_state_nxt = ST_SHIFT;
                end
`endif
            end
`ifdef ALU32_SHIFT_EN
            ST_SHIFT: begin
                if (r_cnt == SHAMT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result/flag registers: loaded on accept or on the final shift, held
    // otherwise so DONE presents stable values under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef ALU32_SHIFT_EN
        end else if (w_last_shift) begin
            r_result   <= w_sh_next;
            r_zero     <= (w_sh_next == '0);
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept && !w_start_shift) begin
`else
        end else if (w_accept) begin
`endif
            r_result   <= w_c_result;
            r_zero     <= (w_c_result == '0);
            r_carry    <= w_c_carry;
            r_overflow <= w_c_overflow;
            r_illegal  <= w_c_illegal;
        end
    end

endmodule

// File: tb/tb_alu32_seq.sv
// Self-checking bench for alu32_seq. Follows ALU32_SHIFT_EN so the same
// file checks either build.
module tb_alu32_seq;

`ifdef ALU32_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero, carry, overflow, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    // Reference: expected result/flags and cycles from accept edge to out_valid.
    function automatic void model(input logic [3:0] m_op, input logic [31:0] m_a,
                                  input logic [31:0] m_b, output logic [31:0] r,
                                  output logic z, output logic c, output logic v,
                                  output logic il, output int lat);
        logic [32:0] s;
        int k;
        k = int'(m_b[4:0]);
        r = 32'd0; c = 1'b0; v = 1'b0; il = 1'b0; lat = 0;
        case (m_op)
            4'd0: r = ~m_a;
            4'd1: r = m_a & m_b;
            4'd2: r = m_a | m_b;
            4'd3: r = m_a ^ m_b;
            4'd4: begin
                s = {1'b0, m_a} + {1'b0, m_b};
                r = s[31:0];
                c = s[32];
                v = (m_a[31] == m_b[31]) && (r[31] != m_a[31]);
            end
            4'd5: begin
                r = m_a - m_b;
                c = (m_a >= m_b);
                v = (m_a[31] != m_b[31]) && (r[31] != m_a[31]);
            end
            4'd6, 4'd7, 4'd8: begin
                if (SHIFT_EN) begin
                    if (m_op == 4'd6)      r = m_a << k;
                    else if (m_op == 4'd7) r = m_a >> k;
                    else                   r = $unsigned($signed(m_a) >>> k);
                    lat = k;
                end else begin
                    il = 1'b1;
                end
            end
            default: il = 1'b1;
        endcase
        z = (r == 32'd0);
    endfunction

    // Drive one op, wait (out_ready low) until out_valid; report latency.
    task automatic issue(input logic [3:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, output int lat);
        out_ready = 1'b0;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        int bad;
        @(negedge clk);
        n_tests++;
        if ({out_valid, result, zero, carry, overflow, illegal} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b r=%h z=%b c=%b v=%b il=%b, want all 0",
                     out_valid, result, zero, carry, overflow, illegal);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        // Leave a nonzero result in the output register, then reset mid-op.
        issue(4'd0, 32'd0, 32'd0, lat);
        consume();
        @(negedge clk);
        if (SHIFT_EN) begin op = 4'd6; a = 32'd1; b = 32'd20; end
        else          begin op = 4'd4; a = 32'd3; b = 32'd4;  end
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, result, zero, carry, overflow, illegal} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_midop: got ov=%b r=%h z=%b c=%b v=%b il=%b, want all 0",
                     out_valid, result, zero, carry, overflow, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midop_ready: got %b want 1", in_ready);
        end
        bad = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_stale_valid: out_valid high in %0d cycles, want 0", bad);
        end
    endtask

    task automatic test_add_sub();
        int lat;
        issue(4'd4, 32'h7FFF_FFFF, 32'd1, lat);
        n_tests++;
        if (lat !== 0 || result !== 32'h8000_0000 || overflow !== 1'b1 ||
            carry !== 1'b0 || zero !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ovf: got lat=%0d r=%h v=%b c=%b z=%b il=%b, want lat=0 r=80000000 v=1 c=0 z=0 il=0",
                     lat, result, overflow, carry, zero, illegal);
        end
        consume();
        issue(4'd5, 32'd5, 32'd5, lat);
        n_tests++;
        if (result !== 32'd0 || zero !== 1'b1 || carry !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_eq: got r=%h z=%b c=%b v=%b, want r=0 z=1 c=1 v=0",
                     result, zero, carry, overflow);
        end
        consume();
        issue(4'd5, 32'd0, 32'd1, lat);
        n_tests++;
        if (result !== 32'hFFFF_FFFF || carry !== 1'b0 || zero !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: got r=%h c=%b z=%b v=%b, want r=ffffffff c=0 z=0 v=0",
                     result, carry, zero, overflow);
        end
        consume();
    endtask

    task automatic test_shift();
        int lat;
        issue(4'd8, 32'h8000_0000, 32'd31, lat);
        n_tests++;
        if (SHIFT_EN) begin
            if (lat !== 31 || result !== 32'hFFFF_FFFF || illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL sra31: got lat=%0d r=%h il=%b, want lat=31 r=ffffffff il=0",
                         lat, result, illegal);
            end
        end else begin
            if (lat !== 0 || result !== 32'd0 || illegal !== 1'b1 || zero !== 1'b1) begin
                n_fail++;
                $display("FAIL sra_disabled: got lat=%0d r=%h il=%b z=%b, want lat=0 r=0 il=1 z=1",
                         lat, result, illegal, zero);
            end
        end
        consume();
        issue(4'd6, 32'hDEAD_BEEF, 32'hFFFF_FFE0, lat);
        n_tests++;
        if (SHIFT_EN) begin
            if (lat !== 0 || result !== 32'hDEAD_BEEF || illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL sll0: got lat=%0d r=%h il=%b, want lat=0 r=deadbeef il=0",
                         lat, result, illegal);
            end
        end else begin
            if (lat !== 0 || result !== 32'd0 || illegal !== 1'b1) begin
                n_fail++;
                $display("FAIL sll0_disabled: got lat=%0d r=%h il=%b, want lat=0 r=0 il=1",
                         lat, result, illegal);
            end
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        issue(4'd0, 32'h0F0F_0F0F, 32'd0, lat);
        n_tests++;
        if (result !== 32'hF0F0_F0F0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL not_result: got r=%h ov=%b ir=%b, want r=f0f0f0f0 ov=1 ir=0",
                     result, out_valid, in_ready);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (result !== 32'hF0F0_F0F0 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                zero !== 1'b0 || carry !== 1'b0 || overflow !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold: outputs changed in %0d of 10 stalled cycles, want 0", bad);
        end
        consume();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: got ir=%b ov=%b, want ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_illegal();
        int lat;
        issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, lat);
        n_tests++;
        if (lat !== 0 || illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b1 ||
            carry !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal12: got lat=%0d il=%b r=%h z=%b c=%b v=%b, want lat=0 il=1 r=0 z=1 c=0 v=0",
                     lat, illegal, result, zero, carry, overflow);
        end
        consume();
        issue(4'd1, 32'h0000_00FF, 32'h0000_000F, lat);
        n_tests++;
        if (result !== 32'h0000_000F || illegal !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL and_after_illegal: got r=%h il=%b z=%b, want r=0000000f il=0 z=0",
                     result, illegal, zero);
        end
        consume();
    endtask

    task automatic test_random();
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b, er;
        logic        ez, ec, ev, eil;
        int          el, lat;
        for (int i = 0; i < 40; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            if (i % 4 == 0) r_b = r_a;
            if (i % 5 == 1) r_a = 32'h8000_0000 | r_a;
            model(r_op, r_a, r_b, er, ez, ec, ev, eil, el);
            issue(r_op, r_a, r_b, lat);
            n_tests++;
            if (lat !== el || result !== er || zero !== ez || carry !== ec ||
                overflow !== ev || illegal !== eil) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d r=%h z%b c%b v%b il%b, want lat=%0d r=%h z%b c%b v%b il%b",
                         i, r_op, r_a, r_b, lat, result, zero, carry, overflow, illegal,
                         el, er, ez, ec, ev, eil);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] q[$];
        logic [35:0] got, exp_v;
        logic [31:0] er;
        logic        ez, ec, ev, eil, acc;
        int          el, nacc, nres, cyc, bad;
        nacc = 0; nres = 0; cyc = 0; bad = 0;
        out_ready = 1'b1;
        @(negedge clk);
        op = (($urandom & 1) != 0) ? 4'd12 : 4'($urandom_range(0, 5));
        a = $urandom; b = $urandom; in_valid = 1'b1;
        while (nres < 20 && cyc < 100) begin
            if (out_valid) begin
                got = {result, zero, carry, overflow, illegal};
                if (q.size() == 0) begin
                    bad++;
                end else begin
                    exp_v = q.pop_front();
                    if (got !== exp_v) bad++;
                end
                nres++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                model(op, a, b, er, ez, ec, ev, eil, el);
                q.push_back({er, ez, ec, ev, eil});
                nacc++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                if (nacc < 20) begin
                    op = (($urandom & 1) != 0) ? 4'd12 : 4'($urandom_range(0, 5));
                    a = $urandom; b = $urandom;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (bad != 0 || nres != 20) begin
            n_fail++;
            $display("FAIL b2b_values: got %0d results with %0d wrong, want 20 with 0 wrong", nres, bad);
        end
        n_tests++;
        if (cyc != 40) begin
            n_fail++;
            $display("FAIL b2b_throughput: got %0d cycles for 20 ops, want 40", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift();
        test_backpressure();
        test_illegal();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
